// File: rtl/draw_pkg.sv
// Shared definitions for the rectangle-fill draw scheduler: requester
// indices, default field widths, FSM state encoding and a small helper.
package draw_pkg;

    localparam int NREQ         = 3;
    localparam int BRICK        = 0;
    localparam int BALL         = 1;
    localparam int PADDLE       = 2;

    localparam int DEF_COORD_W  = 10;
    localparam int DEF_DIM_W    = 5;
    localparam int DEF_COLOUR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    // Convert a one-hot requester vector into its index (0 when empty).
    function automatic logic [1:0] oh_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Requester/plot-port bundle between the game logic and the draw scheduler.
interface draw_scheduler_if
    import draw_pkg::*;
#(
    parameter int COORD_W  = DEF_COORD_W,
    parameter int DIM_W    = DEF_DIM_W,
    parameter int COLOUR_W = DEF_COLOUR_W
);
    logic [NREQ-1:0]          req;
    logic [NREQ*COORD_W-1:0]  rect_x;
    logic [NREQ*COORD_W-1:0]  rect_y;
    logic [NREQ*DIM_W-1:0]    rect_w;
    logic [NREQ*DIM_W-1:0]    rect_h;
    logic [NREQ*COLOUR_W-1:0] rect_colour;
    logic [NREQ-1:0]          grant;
    logic [NREQ-1:0]          done;
    logic                     busy;
    logic                     plot;
    logic [COORD_W-1:0]       x_out;
    logic [COORD_W-1:0]       y_out;
    logic [COLOUR_W-1:0]      colour_out;

    modport master (
        output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        input  grant, done, busy, plot, x_out, y_out, colour_out
    );

    modport slave (
        input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        output grant, done, busy, plot, x_out, y_out, colour_out
    );
endinterface

// File: rtl/draw_rr_pick.sv
// Combinational round-robin picker: the requester after last_grant wins,
// wrapping around the three requesters.
module draw_rr_pick
    import draw_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last_grant,
    output logic [NREQ-1:0] pick,
    output logic            valid
);
    logic [1:0] idx;

    // Scan from last_grant+1 and take the first active request.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = 2'((int'(last_grant) + k) % NREQ);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates three rectangle-fill requesters onto a single pixel plot port
// and walks the winner's rectangle row-major, one pixel per cycle.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int COORD_W  = DEF_COORD_W,
    parameter int DIM_W    = DEF_DIM_W,
    parameter int COLOUR_W = DEF_COLOUR_W
) (
    input  logic            clk,
    input  logic            reset,
    draw_scheduler_if.slave bus
);
    state_t              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d, done_q, done_d, pick;
    logic                pick_valid, busy_q, busy_d, plot_q, plot_d;
    logic [COORD_W-1:0]  x_out_q, x_out_d, y_out_q, y_out_d;
    logic [COORD_W-1:0]  x0_q, x0_d, y0_q, y0_d;
    logic [COLOUR_W-1:0] colour_q, colour_d, c0_q, c0_d;
    logic [DIM_W-1:0]    col_q, col_d, row_q, row_d, w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0]    col_inc, row_inc;
    logic [1:0]          last_q, last_d, win_idx;

    draw_rr_pick u_pick (
        .req        (bus.req),
        .last_grant (last_q),
        .pick       (pick),
        .valid      (pick_valid)
    );

    assign win_idx = oh_to_idx(pick);
    assign col_inc = col_q + DIM_W'(1);
    assign row_inc = row_q + DIM_W'(1);

    // Next-state, job capture and registered-output computation.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        plot_d   = 1'b0;
        x_out_d  = x_out_q;
        y_out_d  = y_out_q;
        colour_d = colour_q;
        col_d    = col_q;
        row_d    = row_q;
        last_d   = last_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        c0_d     = c0_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = LOAD;
                    grant_d = pick;
                    x0_d    = bus.rect_x[int'(win_idx)*COORD_W +: COORD_W];
                    y0_d    = bus.rect_y[int'(win_idx)*COORD_W +: COORD_W];
                    w_d     = bus.rect_w[int'(win_idx)*DIM_W +: DIM_W];
                    h_d     = bus.rect_h[int'(win_idx)*DIM_W +: DIM_W];
                    c0_d    = bus.rect_colour[int'(win_idx)*COLOUR_W +: COLOUR_W];
                end
            end
            LOAD: begin
                col_d = '0;
                row_d = '0;
                if (w_q == '0 || h_q == '0) begin
                    state_d = DONE;
                    done_d  = grant_q;
                end else begin
                    state_d  = FILL;
                    plot_d   = 1'b1;
                    x_out_d  = x0_q;
                    y_out_d  = y0_q;
                    colour_d = c0_q;
                end
            end
            FILL: begin
                if (col_q == w_q - DIM_W'(1)) begin
                    col_d = '0;
                    if (row_q == h_q - DIM_W'(1)) begin
                        // Last pixel is on the port this cycle; finish.
                        state_d = DONE;
                        row_d   = '0;
                        done_d  = grant_q;
                    end else begin
                        row_d   = row_inc;
                        plot_d  = 1'b1;
                        x_out_d = x0_q;
                        y_out_d = y0_q + COORD_W'(row_inc);
                    end
                end else begin
                    col_d   = col_inc;
                    plot_d  = 1'b1;
                    x_out_d = x0_q + COORD_W'(col_inc);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = oh_to_idx(grant_q);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_out_q  <= '0;
            y_out_q  <= '0;
            colour_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            last_q   <= 2'(PADDLE);
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            c0_q     <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            plot_q   <= plot_d;
            x_out_q  <= x_out_d;
            y_out_q  <= y_out_d;
            colour_q <= colour_d;
            col_q    <= col_d;
            row_q    <= row_d;
            last_q   <= last_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            c0_q     <= c0_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.plot       = plot_q;
    assign bus.x_out      = x_out_q;
    assign bus.y_out      = y_out_q;
    assign bus.colour_out = colour_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed job table, grant-order and mid-fill
// reset sequences, and random traffic against a job-timeline model.
module tb_draw_scheduler;
    import draw_pkg::*;

    localparam int CW = 10;
    localparam int DW = 5;
    localparam int KW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    draw_scheduler_if #(.COORD_W(CW), .DIM_W(DW), .COLOUR_W(KW)) bus ();

    draw_scheduler #(.COORD_W(CW), .DIM_W(DW), .COLOUR_W(KW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Job-timeline model: m_t = -1 when idle, else cycles since grant.
    int m_t = -1, m_last = 2, m_win = 0;
    int m_x = 0, m_y = 0, m_w = 0, m_h = 0, m_c = 0;

    function automatic int rr_ref(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
        bus.rect_x[i*CW +: CW]      = CW'(x);
        bus.rect_y[i*CW +: CW]      = CW'(y);
        bus.rect_w[i*DW +: DW]      = DW'(w);
        bus.rect_h[i*DW +: DW]      = DW'(h);
        bus.rect_colour[i*KW +: KW] = KW'(c);
    endtask

    // Advance the model on each clock edge (or reset).
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_t = -1;
            m_last = 2;
        end else if (m_t >= 0) begin
            if (m_t == m_w * m_h + 1) begin
                m_last = m_win;
                m_t = -1;
            end else begin
                m_t++;
            end
        end else if (bus.req != 3'b000) begin
            m_win = rr_ref(bus.req, m_last);
            m_x = int'(bus.rect_x[m_win*CW +: CW]);
            m_y = int'(bus.rect_y[m_win*CW +: CW]);
            m_w = int'(bus.rect_w[m_win*DW +: DW]);
            m_h = int'(bus.rect_h[m_win*DW +: DW]);
            m_c = int'(bus.rect_colour[m_win*KW +: KW]);
            m_t = 0;
        end
    end

    // Compare every cycle's outputs with the model's expectation.
    initial forever begin
        logic [2:0] eg, ed;
        logic eb, ep;
        int ex, ey, ec, ax, ay, ac, k, wh;
        @(negedge clk);
        if (reset === 1'b0) begin
            wh = m_w * m_h;
            eb = (m_t >= 0);
            eg = eb ? (3'b001 << m_win) : 3'b000;
            ep = (m_t >= 1) && (m_t <= wh);
            ed = (eb && m_t == wh + 1) ? eg : 3'b000;
            ex = 0; ey = 0; ec = 0; ax = 0; ay = 0; ac = 0;
            if (ep) begin
                k  = m_t - 1;
                ex = (m_x + k % m_w) % 1024;
                ey = (m_y + k / m_w) % 1024;
                ec = m_c;
                ax = int'(bus.x_out);
                ay = int'(bus.y_out);
                ac = int'(bus.colour_out);
            end
            n_vec++;
            if (bus.grant !== eg || bus.done !== ed || bus.busy !== eb || bus.plot !== ep ||
                ax != ex || ay != ey || ac != ec) begin
                n_err++;
                $display("FAIL cycle_model @%0t: got grant=%b done=%b busy=%b plot=%b x=%0d y=%0d c=%0d, expected grant=%b done=%b busy=%b plot=%b x=%0d y=%0d c=%0d",
                         $time, bus.grant, bus.done, bus.busy, bus.plot, ax, ay, ac,
                         eg, ed, eb, ep, ex, ey, ec);
            end
        end
    end

    typedef struct {
        int who, x, y, w, h, c;
        bit chg;
        int e_plots, e_fx, e_fy, e_lx, e_ly, e_done;
    } vec_t;

    // One job from a single requester; collects plots and done timing.
    task automatic run_job(input vec_t v, input string nm);
        int cyc = 0, plots = 0, fx = -1, fy = -1, lx = -1, ly = -1, dcyc = -1, dcnt = 0;
        bit seen_grant = 0, changed = 0;
        @(negedge clk);
        set_rect(v.who, v.x, v.y, v.w, v.h, v.c);
        bus.req[v.who] = 1'b1;
        while (cyc < 200 && !(dcyc >= 0 && !bus.busy)) begin
            @(negedge clk);
            cyc++;
            if (bus.plot) begin
                if (plots == 0) begin fx = int'(bus.x_out); fy = int'(bus.y_out); end
                lx = int'(bus.x_out);
                ly = int'(bus.y_out);
                plots++;
            end
            if (bus.done[v.who]) begin
                if (dcyc < 0) dcyc = cyc;
                dcnt++;
                bus.req[v.who] = 1'b0;
            end
            if (v.chg && seen_grant && !changed) begin
                bus.rect_x[v.who*CW +: CW] = CW'(100);
                changed = 1;
            end
            if (bus.grant[v.who]) seen_grant = 1;
        end
        bus.req[v.who] = 1'b0;
        check({nm, " in_time"}, int'(cyc < 200), 1);
        check({nm, " plots"}, plots, v.e_plots);
        check({nm, " first_x"}, fx, v.e_fx);
        check({nm, " first_y"}, fy, v.e_fy);
        check({nm, " last_x"}, lx, v.e_lx);
        check({nm, " last_y"}, ly, v.e_ly);
        check({nm, " done_latency"}, dcyc, v.e_done);
        check({nm, " done_pulses"}, dcnt, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // All three requesters; returns the grant order of the first n jobs.
    task automatic grant_order(input int n, output int order[$]);
        logic [2:0] prev = 3'b000;
        int cyc = 0;
        order = {};
        while (cyc < 400 && !(order.size() >= n && !bus.busy && bus.req == 3'b000)) begin
            @(negedge clk);
            cyc++;
            if (bus.grant != 3'b000 && prev == 3'b000) order.push_back(int'(oh_to_idx(bus.grant)));
            prev = bus.grant;
            for (int i = 0; i < 3; i++) if (bus.done[i]) bus.req[i] = 1'b0;
        end
        check("order in_time", int'(cyc < 400), 1);
    endtask

    vec_t tbl[7];
    int order[$];

    initial begin
        reset = 1'b1;
        bus.req = '0;
        bus.rect_x = '0; bus.rect_y = '0; bus.rect_w = '0; bus.rect_h = '0; bus.rect_colour = '0;

        // Reset state
        @(negedge clk);
        check("reset outputs", int'({bus.grant, bus.done, bus.busy, bus.plot, bus.x_out, bus.y_out, bus.colour_out}), 0);
        @(negedge clk);
        reset = 1'b0;

        //            who  x     y    w   h  c  chg plots fx    fy   lx  ly   done
        tbl[0] = '{0,   20,   10,  10, 5, 4, 0,  50,   20,   10,  29, 14,  52};
        tbl[1] = '{1,   5,    5,   0,  4, 1, 0,  0,    -1,   -1,  -1, -1,  2};
        tbl[2] = '{2,   1020, 479, 8,  1, 7, 0,  8,    1020, 479, 3,  479, 10};
        tbl[3] = '{0,   20,   10,  10, 5, 4, 1,  50,   20,   10,  29, 14,  52};
        tbl[4] = '{1,   1,    1,   1,  1, 2, 0,  1,    1,    1,   1,  1,   3};
        tbl[5] = '{2,   0,    1022,3,  4, 5, 0,  12,   0,    1022,2,  1,   14};
        tbl[6] = '{0,   7,    7,   4,  0, 6, 0,  0,    -1,   -1,  -1, -1,  2};
        for (int i = 0; i < 7; i++) run_job(tbl[i], $sformatf("job%0d", i));

        // Round-robin order from a fresh reset, twice
        pulse_reset();
        for (int i = 0; i < 3; i++) set_rect(i, 10 * i, 5, 2, 1, i + 1);
        @(negedge clk);
        bus.req = 3'b111;
        grant_order(3, order);
        check("rr_a size", order.size(), 3);
        for (int i = 0; i < 3; i++) check($sformatf("rr_a[%0d]", i), (i < order.size()) ? order[i] : -1, i);
        @(negedge clk);
        bus.req = 3'b111;
        grant_order(3, order);
        for (int i = 0; i < 3; i++) check($sformatf("rr_b[%0d]", i), (i < order.size()) ? order[i] : -1, i);

        // Reset during the 7th fill cycle of the 10x5 job
        pulse_reset();
        begin
            int plots = 0, cyc = 0, dcnt = 0;
            set_rect(0, 20, 10, 10, 5, 4);
            set_rect(2, 300, 200, 2, 2, 1);
            @(negedge clk);
            bus.req[0] = 1'b1;
            while (plots < 7 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (bus.plot) plots++;
                if (bus.done != 3'b000) dcnt++;
            end
            check("pre_reset plots", plots, 7);
            bus.req[2] = 1'b1;
            #1 reset = 1'b1;
            #1 check("async drop", int'({bus.plot, bus.grant, bus.busy, bus.done}), 0);
            #1 reset = 1'b0;
            check("no done before reset", dcnt, 0);
            grant_order(2, order);
            check("post_reset jobs", order.size(), 2);
            check("post_reset first", (order.size() > 0) ? order[0] : -1, 0);
            check("post_reset second", (order.size() > 1) ? order[1] : -1, 2);
        end

        // Random traffic; every cycle is checked by the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (bus.req[i] && bus.done[i]) begin
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(3) == 0) begin
                    set_rect(i, ($urandom_range(1)) ? int'($urandom_range(1023)) : int'($urandom_range(1023, 1018)),
                             ($urandom_range(1)) ? int'($urandom_range(1023)) : int'($urandom_range(1023, 1019)),
                             int'($urandom_range(5)), int'($urandom_range(4)), int'($urandom_range(7)));
                    bus.req[i] = 1'b1;
                end else if (bus.req[i] && $urandom_range(4) == 0) begin
                    set_rect(i, int'($urandom_range(1023)), int'($urandom_range(1023)),
                             int'($urandom_range(5)), int'($urandom_range(4)), int'($urandom_range(7)));
                end
            end
        end
        begin
            int cyc = 0;
            while (cyc < 300 && (bus.busy || bus.req != 3'b000)) begin
                @(negedge clk);
                cyc++;
                for (int i = 0; i < 3; i++) if (bus.done[i]) bus.req[i] = 1'b0;
            end
            check("drain in_time", int'(cyc < 300), 1);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
